upstream_order_scheduler: RTL and testbench
===========================================

Name: upstream_order_scheduler

Overview:
- Controller that sequences the upstream risk datapath: takes new-order and max-limit update requests, arbitrates between them and drives the upstream client RAM (read, risk check, write-back) one transaction at a time.
- Sits between the order-entry front end and the upstream RAM / downstream cancelled-orders RAM.
- Replaces ad hoc state-machine wiring with a clean valid/ready front end and explicit per-order pass/reject results.

Parameters:
DATA_W, 32, amount / limit width
ADDR_W, 10, client id width (RAM depth 2**ADDR_W)
CNT_W, 16, reject counter width

Ports:
clk  in  1  single clock, all logic on rising edge
HRESETn  in  1  synchronous, active-low reset
ord_valid  in  1  new order request
ord_ready  out  1  order accepted this cycle when ord_valid && ord_ready
ord_client_id  in  ADDR_W  order client
ord_amount  in  DATA_W  order amount (unsigned)
max_valid  in  1  max-limit update request
max_ready  out  1  max update accepted when max_valid && max_ready
max_client_id  in  ADDR_W  client whose limit changes
max_amount  in  DATA_W  new limit (unsigned)
ram_addr  out  ADDR_W  upstream RAM address (read and write)
ram_rd_en  out  1  upstream RAM read strobe; data valid next cycle
ram_acc  in  DATA_W  accumulated orders read data
ram_max  in  DATA_W  max_to_trade read data
ram_cancelled  in  DATA_W  cancelled orders for client, valid with ram_acc
ram_wr_en  out  1  RAM write strobe
ram_wr_max  out  1  1 = write the max field, 0 = write the accumulated field
ram_wr_data  out  DATA_W  write data
ord_done  out  1  one-cycle pulse: order decision available
ord_pass  out  1  valid with ord_done; 1 = order passed and was committed
max_done  out  1  one-cycle pulse: limit written
busy  out  1  high whenever state != IDLE
rej_count  out  CNT_W  saturating count of rejected orders

Behaviour:
- States: IDLE, RD, CHK, WR_ORD, REJ, WR_MAX. All outputs decode from state plus captured registers.
- Reset: HRESETn low at an edge forces IDLE, captured id/amount = 0, rr pointer = max-first, rej_count = 0. All strobes, ord_done, ord_pass, max_done and busy read 0.
- Reset mid-operation:
  - ram_wr_en and ram_rd_en are gated by HRESETn, so no RAM access occurs in any cycle where HRESETn is low.
  - The in-flight transaction is dropped and no done pulse is issued.
- IDLE arbitration:
  - Only one request valid: its ready = 1.
  - Both valid: round-robin. The rr pointer selects the winner, and only the winner's ready is high. The pointer flips to the other requester after each grant.
  - Both ready outputs are 0 outside IDLE.
  - On a handshake, capture client_id and amount. Order goes to RD; max goes to WR_MAX.
- RD (1 cycle): ram_addr = captured id, ram_rd_en = 1, then go to CHK.
- CHK (1 cycle):
  - exposure = acc + amount − cancelled, computed at DATA_W+2 bits signed. A negative result clamps to 0.
  - pass iff exposure <= ram_max (unsigned).
  - Go to WR_ORD on pass, REJ on fail.
- WR_ORD (1 cycle):
  - ram_wr_en = 1, ram_wr_max = 0, ram_addr = id.
  - ram_wr_data = acc + amount, saturating at all-ones. acc is registered in CHK.
  - ord_done = 1, ord_pass = 1. Go to IDLE.
- REJ (1 cycle): ord_done = 1, ord_pass = 0, no write, rej_count += 1 (saturates at all-ones). Go to IDLE.
- WR_MAX (1 cycle): ram_wr_en = 1, ram_wr_max = 1, ram_wr_data = captured amount, max_done = 1. Go to IDLE.
- Latency (handshake at edge n):
  - Order: RD in cycle n+1, CHK in n+2, done in n+3. Order issue interval is 4 cycles.
  - Max: done in n+1. Max issue interval is 2 cycles.
- Serialisation: one transaction at a time, so there is no read-after-write hazard. A write in cycle k is visible to a read issued at k+2 or later.
- Inputs are sampled only at the handshake. Changes to id/amount afterwards have no effect.

Test Plan:
- Reset, then order id=5, amt=100 with RAM acc=200, max=500, cancelled=50 → ord_ready pulse; RD at n+1; at n+3 ord_done=1, ord_pass=1, ram_wr_en=1, ram_wr_max=0, ram_wr_data=300, addr=5.
- Order amt=400, acc=200, max=500, cancelled=50 (exposure 550) → REJ: ord_done=1, ord_pass=0, no ram_wr_en, rej_count 0→1.
- Boundary checks:
  - exposure exactly equal to max passes.
  - cancelled=1000 > acc+amt clamps to 0 and passes.
  - acc=0xFFFFFFF0 with amt=0x20 and max=0xFFFFFFFF → ram_wr_data=0xFFFFFFFF.
- ord_valid and max_valid held high together for 12 cycles → grants alternate max, order, max, order starting max-first after reset; max write has ram_wr_max=1 and data=max_amount.
- HRESETn low during CHK of a passing order → no ram_wr_en, no ord_done, busy=0 next cycle; the next order after release completes normally.
- 2**CNT_W+3 rejected orders → rej_count saturates at 0xFFFF.

Source files
------------

// File: rtl/upstream_order_scheduler.sv
// ---------------------------------------------------------------------------
// upstream_order_scheduler
//
// Sequences the upstream risk datapath one transaction at a time. New orders
// and max-limit updates arrive on two valid/ready front ends; an arbiter in
// IDLE picks one (round-robin when both are pending). An order reads the
// client's RAM entry, runs the exposure check and either writes back the new
// accumulated amount or rejects. A max update writes the limit field directly.
//
// Ports:
//   clk, HRESETn              clock, synchronous active-low reset
//   ord_valid/ready/...       new order request (client id, amount)
//   max_valid/ready/...       max-limit update request (client id, new limit)
//   ram_addr, ram_rd_en       upstream RAM address / read strobe (data +1 cycle)
//   ram_acc/max/cancelled     RAM read data
//   ram_wr_en/wr_max/wr_data  RAM write strobe, field select, write data
//   ord_done, ord_pass        order decision pulse and result
//   max_done                  limit write pulse
//   busy                      controller not in IDLE
//   rej_count                 saturating rejected-order count
// ---------------------------------------------------------------------------
module upstream_order_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              HRESETn,
    input  logic              ord_valid,
    output logic              ord_ready,
    input  logic [ADDR_W-1:0] ord_client_id,
    input  logic [DATA_W-1:0] ord_amount,
    input  logic              max_valid,
    output logic              max_ready,
    input  logic [ADDR_W-1:0] max_client_id,
    input  logic [DATA_W-1:0] max_amount,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_acc,
    input  logic [DATA_W-1:0] ram_max,
    input  logic [DATA_W-1:0] ram_cancelled,
    output logic              ram_wr_en,
    output logic              ram_wr_max,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ord_done,
    output logic              ord_pass,
    output logic              max_done,
    output logic              busy,
    output logic [CNT_W-1:0]  rej_count
);

    localparam int EXP_W = DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        CHK    = 3'd2,
        WR_ORD = 3'd3,
        REJ    = 3'd4,
        WR_MAX = 3'd5
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   id_reg;
    logic [DATA_W-1:0]   amount_reg;
    logic [DATA_W-1:0]   acc_reg;
    logic                rr_max_reg;     // 1: max requester wins a tie
    logic [CNT_W-1:0]    rej_count_reg;

    logic                grant_ord;
    logic                grant_max;
    logic [EXP_W-1:0]    exposure_raw;
    logic [EXP_W-1:0]    exposure;
    logic                chk_pass;
    logic [DATA_W:0]     sum_full;
    logic [DATA_W-1:0]   sum_sat;

    // Arbitration: only in IDLE and never while reset is asserted, so a
    // request presented during reset is not considered accepted.
    always_comb begin
        grant_ord = 1'b0;
        grant_max = 1'b0;
        if (state_reg == IDLE && HRESETn) begin
            if (ord_valid && max_valid) begin
                grant_max = rr_max_reg;
                grant_ord = !rr_max_reg;
            end else begin
                grant_max = max_valid;
                grant_ord = ord_valid;
            end
        end
    end

    assign ord_ready = grant_ord;
    assign max_ready = grant_max;

    // Exposure = acc + amount - cancelled. Two extra bits hold the carry of
    // the sum and the sign of the difference; a set MSB means negative.
    assign exposure_raw = {2'b00, ram_acc} + {2'b00, amount_reg} - {2'b00, ram_cancelled};
    assign exposure     = exposure_raw[EXP_W-1] ? '0 : exposure_raw;
    assign chk_pass     = (exposure <= {2'b00, ram_max});

    // Committed accumulated value saturates instead of wrapping.
    assign sum_full = {1'b0, acc_reg} + {1'b0, amount_reg};
    assign sum_sat  = sum_full[DATA_W] ? '1 : sum_full[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            state_reg     <= IDLE;
            id_reg        <= '0;
            amount_reg    <= '0;
            acc_reg       <= '0;
            rr_max_reg    <= 1'b1;
            rej_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_ord) begin
                id_reg     <= ord_client_id;
                amount_reg <= ord_amount;
                rr_max_reg <= 1'b1;
            end else if (grant_max) begin
                id_reg     <= max_client_id;
                amount_reg <= max_amount;
                rr_max_reg <= 1'b0;
            end
            if (state_reg == CHK) begin
                acc_reg <= ram_acc;
            end
            if (state_reg == REJ && rej_count_reg != '1) begin
                rej_count_reg <= rej_count_reg + CNT_W'(1);
            end
        end
    end

    // Next state and outputs. RAM strobes and done pulses are qualified by
    // HRESETn so a transaction caught by reset leaves no trace.
    always_comb begin
        state_next  = state_reg;
        ram_addr    = id_reg;
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_max  = 1'b0;
        ram_wr_data = '0;
        ord_done    = 1'b0;
        ord_pass    = 1'b0;
        max_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_ord) begin
                    state_next = RD;
                end else if (grant_max) begin
                    state_next = WR_MAX;
                end
            end
            RD: begin
                ram_rd_en  = HRESETn;
                state_next = CHK;
            end
            CHK: begin
                state_next = chk_pass ? WR_ORD : REJ;
            end
            WR_ORD: begin
                ram_wr_en   = HRESETn;
                ram_wr_data = sum_sat;
                ord_done    = HRESETn;
                ord_pass    = HRESETn;
                state_next  = IDLE;
            end
            REJ: begin
                ord_done   = HRESETn;
                state_next = IDLE;
            end
            WR_MAX: begin
                ram_wr_en   = HRESETn;
                ram_wr_max  = 1'b1;
                ram_wr_data = amount_reg;
                max_done    = HRESETn;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign rej_count = rej_count_reg;

endmodule

// File: tb/tb_upstream_order_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for upstream_order_scheduler. A small read-only RAM model answers
// reads; every expected order/max result is pushed to a scoreboard when the
// request is driven and popped when the DUT pulses ord_done/max_done.
// A second instance with a 4-bit reject counter shares all inputs so that
// counter saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_upstream_order_scheduler;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              HRESETn;
    logic              ord_valid;
    logic              ord_ready;
    logic [ADDR_W-1:0] ord_client_id;
    logic [DATA_W-1:0] ord_amount;
    logic              max_valid;
    logic              max_ready;
    logic [ADDR_W-1:0] max_client_id;
    logic [DATA_W-1:0] max_amount;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_acc;
    logic [DATA_W-1:0] ram_max;
    logic [DATA_W-1:0] ram_cancelled;
    logic              ram_wr_en;
    logic              ram_wr_max;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ord_done;
    logic              ord_pass;
    logic              max_done;
    logic              busy;
    logic [CNT_W-1:0]  rej_count;

    // small-counter instance outputs
    logic              s_ord_ready, s_max_ready, s_ram_rd_en, s_ram_wr_en, s_ram_wr_max;
    logic [ADDR_W-1:0] s_ram_addr;
    logic [DATA_W-1:0] s_ram_wr_data;
    logic              s_ord_done, s_ord_pass, s_max_done, s_busy;
    logic [3:0]        s_rej_count;

    upstream_order_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .HRESETn(HRESETn),
        .ord_valid(ord_valid), .ord_ready(ord_ready),
        .ord_client_id(ord_client_id), .ord_amount(ord_amount),
        .max_valid(max_valid), .max_ready(max_ready),
        .max_client_id(max_client_id), .max_amount(max_amount),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
        .ram_acc(ram_acc), .ram_max(ram_max), .ram_cancelled(ram_cancelled),
        .ram_wr_en(ram_wr_en), .ram_wr_max(ram_wr_max), .ram_wr_data(ram_wr_data),
        .ord_done(ord_done), .ord_pass(ord_pass), .max_done(max_done),
        .busy(busy), .rej_count(rej_count)
    );

    upstream_order_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut_s (
        .clk(clk), .HRESETn(HRESETn),
        .ord_valid(ord_valid), .ord_ready(s_ord_ready),
        .ord_client_id(ord_client_id), .ord_amount(ord_amount),
        .max_valid(max_valid), .max_ready(s_max_ready),
        .max_client_id(max_client_id), .max_amount(max_amount),
        .ram_addr(s_ram_addr), .ram_rd_en(s_ram_rd_en),
        .ram_acc(ram_acc), .ram_max(ram_max), .ram_cancelled(ram_cancelled),
        .ram_wr_en(s_ram_wr_en), .ram_wr_max(s_ram_wr_max), .ram_wr_data(s_ram_wr_data),
        .ord_done(s_ord_done), .ord_pass(s_ord_pass), .max_done(s_max_done),
        .busy(s_busy), .rej_count(s_rej_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-only RAM model with one-cycle registered read.
    logic [DATA_W-1:0] acc_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] max_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] canc_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_acc       <= acc_mem[ram_addr];
            ram_max       <= max_mem[ram_addr];
            ram_cancelled <= canc_mem[ram_addr];
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] id;
        logic [DATA_W-1:0] amt;
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] mx;
        logic [DATA_W-1:0] canc;
        logic              pass;
        logic [DATA_W-1:0] data;
    } vec_t;

    typedef struct {
        logic              is_max;
        logic [ADDR_W-1:0] addr;
        logic              pass;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   tests;
    int   fails;
    int   rej_model;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    task automatic set_ram(input logic [ADDR_W-1:0] id, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] c);
        acc_mem[id]  = a;
        max_mem[id]  = m;
        canc_mem[id] = c;
    endtask

    task automatic check_rej();
        chk("rej_count", 64'(rej_count), 64'(rej_model));
        chk("rej_count_small", 64'(s_rej_count), 64'((rej_model > 15) ? 15 : rej_model));
    endtask

    // Scoreboard consumer: one line per completed transaction.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ord_done || max_done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: ord_done=%0b max_done=%0b none outstanding", ord_done, max_done);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", {62'd0, ord_done, max_done}, e.is_max ? 64'd1 : 64'd2);
                    if (!e.is_max) begin
                        chk("ord_pass", 64'(ord_pass), 64'(e.pass));
                        chk("ord_wr_en", 64'(ram_wr_en), 64'(e.pass));
                        if (e.pass) begin
                            chk("ord_wr_max", 64'(ram_wr_max), 64'd0);
                            chk("ord_wr_addr", 64'(ram_addr), 64'(e.addr));
                            chk("ord_wr_data", 64'(ram_wr_data), 64'(e.data));
                        end
                        $display("[TB] order id=%0d pass=%0b wr_data=0x%08h", e.addr, ord_pass, ram_wr_data);
                    end else begin
                        chk("max_wr_en", 64'(ram_wr_en), 64'd1);
                        chk("max_wr_max", 64'(ram_wr_max), 64'd1);
                        chk("max_wr_addr", 64'(ram_addr), 64'(e.addr));
                        chk("max_wr_data", 64'(ram_wr_data), 64'(e.data));
                        $display("[TB] max id=%0d wr_data=0x%08h", e.addr, ram_wr_data);
                    end
                end
            end else if (ram_wr_en) begin
                tests++;
                fails++;
                $display("FAIL spurious_write: ram_wr_en=1 addr=%0d without done pulse", ram_addr);
            end
        end
    endtask

    task automatic order_handshake(input logic [ADDR_W-1:0] id, input logic [DATA_W-1:0] amt);
        bit hs;
        ord_client_id = id;
        ord_amount    = amt;
        ord_valid     = 1'b1;
        hs = 0;
        for (int c = 0; c < 16 && !hs; c++) begin
            @(negedge clk);
            if (ord_ready) hs = 1;
        end
        chk("ord_handshake", 64'(hs), 64'd1);
        @(posedge clk);
        #1;
        // Later input changes must not affect the captured transaction.
        ord_valid     = 1'b0;
        ord_client_id = ADDR_W'($urandom);
        ord_amount    = $urandom;
    endtask

    task automatic run_order(input logic [ADDR_W-1:0] id, input logic [DATA_W-1:0] amt,
                             input logic pass, input logic [DATA_W-1:0] data);
        exp_t e;
        e.is_max = 1'b0;
        e.addr   = id;
        e.pass   = pass;
        e.data   = data;
        sb.push_back(e);
        if (!pass && rej_model < 65535) rej_model++;
        order_handshake(id, amt);
        @(negedge clk);                                   // n+1: RD
        chk("rd_en_n1", 64'(ram_rd_en), 64'd1);
        chk("rd_addr_n1", 64'(ram_addr), 64'(id));
        @(negedge clk);                                   // n+2: CHK
        chk("done_early_n2", 64'(ord_done), 64'd0);
        chk("busy_n2", 64'(busy), 64'd1);
        @(negedge clk);                                   // n+3: decision
        chk("done_n3", 64'(ord_done), 64'd1);
        @(negedge clk);                                   // n+4: back in IDLE
        chk("busy_n4", 64'(busy), 64'd0);
        check_rej();
        @(posedge clk);
        #1;
    endtask

    task automatic run_max(input logic [ADDR_W-1:0] id, input logic [DATA_W-1:0] amt);
        exp_t e;
        bit hs;
        e.is_max = 1'b1;
        e.addr   = id;
        e.pass   = 1'b1;
        e.data   = amt;
        sb.push_back(e);
        max_client_id = id;
        max_amount    = amt;
        max_valid     = 1'b1;
        hs = 0;
        for (int c = 0; c < 16 && !hs; c++) begin
            @(negedge clk);
            if (max_ready) hs = 1;
        end
        chk("max_handshake", 64'(hs), 64'd1);
        @(posedge clk);
        #1;
        max_valid     = 1'b0;
        max_client_id = ADDR_W'($urandom);
        max_amount    = $urandom;
        @(negedge clk);
        chk("max_done_n1", 64'(max_done), 64'd1);
        @(negedge clk);
        chk("max_busy_n2", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Reset pulse landing in RD (1), CHK (2) or WR_ORD (3) of a passing order.
    task automatic reset_during(input int phase, input logic [ADDR_W-1:0] id);
        order_handshake(id, 32'd5);
        for (int p = 1; p < phase; p++) begin
            @(posedge clk);
            #1;
        end
        HRESETn = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", 64'(ram_rd_en), 64'd0);
        chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
        chk("rst_ord_done", 64'(ord_done), 64'd0);
        @(posedge clk);
        #1;
        HRESETn   = 1'b1;
        rej_model = 0;
        @(negedge clk);
        chk("rst_busy_after", 64'(busy), 64'd0);
        chk("rst_done_after", 64'(ord_done), 64'd0);
        check_rej();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] grant_seq [0:7];
        logic [3:0] grant_req [0:3];
        int ng;

        tests = 0;
        fails = 0;
        rej_model = 0;
        HRESETn = 1'b0;
        ord_valid = 1'b0;
        max_valid = 1'b0;
        ord_client_id = '0;
        ord_amount = '0;
        max_client_id = '0;
        max_amount = '0;

        //          id      amt           acc           max           canc        pass  data
        vecs[0] = '{10'd5,  32'd100,      32'd200,      32'd500,      32'd50,     1'b1, 32'd300};
        vecs[1] = '{10'd5,  32'd400,      32'd200,      32'd500,      32'd50,     1'b0, 32'd0};
        vecs[2] = '{10'd7,  32'd300,      32'd250,      32'd500,      32'd50,     1'b1, 32'd550};
        vecs[3] = '{10'd9,  32'd10,       32'd20,       32'd0,        32'd1000,   1'b1, 32'd30};
        vecs[4] = '{10'd11, 32'h20,       32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20,     1'b1, 32'hFFFFFFFF};
        vecs[5] = '{10'd12, 32'd1,        32'd500,      32'd500,      32'd0,      1'b0, 32'd0};
        vecs[6] = '{10'd1023, 32'd0,      32'd0,        32'd0,        32'd0,      1'b1, 32'd0};
        vecs[7] = '{10'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,      1'b0, 32'd0};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rd_en", 64'(ram_rd_en), 64'd0);
        chk("reset_wr_en", 64'(ram_wr_en), 64'd0);
        chk("reset_done", {62'd0, ord_done, max_done}, 64'd0);
        chk("reset_ord_pass", 64'(ord_pass), 64'd0);
        check_rej();
        @(posedge clk);
        #1;
        HRESETn = 1'b1;

        // Table-driven orders.
        for (int i = 0; i < 8; i++) begin
            set_ram(vecs[i].id, vecs[i].acc, vecs[i].mx, vecs[i].canc);
            run_order(vecs[i].id, vecs[i].amt, vecs[i].pass, vecs[i].data);
        end
        run_max(10'd40, 32'h12345678);
        run_max(10'd1023, 32'hFFFFFFFF);
        drain("drain_table");

        // Round-robin: both requesters held for 12 cycles after reset.
        HRESETn = 1'b0;
        @(posedge clk);
        #1;
        HRESETn = 1'b1;
        rej_model = 0;
        set_ram(10'd3, 32'd0, 32'd1000, 32'd0);
        ord_client_id = 10'd3;
        ord_amount    = 32'd10;
        max_client_id = 10'd20;
        max_amount    = 32'hABCD0000;
        ord_valid     = 1'b1;
        max_valid     = 1'b1;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ord_ready && max_ready) begin
                tests++;
                fails++;
                $display("FAIL both_ready: ord_ready=1 max_ready=1 required one-hot");
            end
            if ((ord_ready || max_ready) && ng < 8) begin
                exp_t e;
                e.is_max = max_ready;
                e.addr   = max_ready ? 10'd20 : 10'd3;
                e.pass   = 1'b1;
                e.data   = max_ready ? 32'hABCD0000 : 32'd10;
                sb.push_back(e);
                grant_seq[ng] = max_ready ? 4'hA : 4'h5;
                ng++;
            end
            @(posedge clk);
            #1;
        end
        ord_valid = 1'b0;
        max_valid = 1'b0;
        grant_req[0] = 4'hA;
        grant_req[1] = 4'h5;
        grant_req[2] = 4'hA;
        grant_req[3] = 4'h5;
        chk("rr_grant_count", 64'(ng), 64'd4);
        for (int i = 0; i < 4 && i < ng; i++) begin
            chk("rr_grant_order", 64'(grant_seq[i]), 64'(grant_req[i]));
        end
        drain("drain_rr");
        @(negedge clk);
        chk("rr_busy_end", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a passing order.
        set_ram(10'd4, 32'd1, 32'd100, 32'd0);
        reset_during(2, 10'd4);
        run_order(10'd4, 32'd5, 1'b1, 32'd6);
        reset_during(1, 10'd4);
        reset_during(3, 10'd4);
        run_order(10'd4, 32'd7, 1'b1, 32'd8);

        // Reject-counter saturation on the 4-bit instance.
        set_ram(10'd30, 32'd100, 32'd50, 32'd0);
        for (int i = 0; i < 19; i++) begin
            run_order(10'd30, 32'd1, 1'b0, 32'd0);
        end
        chk("rej_small_saturated", 64'(s_rej_count), 64'hF);
        drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
